insn_encoder: RTL and testbench
===============================

INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of encoded-instruction buffer entries (power of two, 2..16).
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory address width.
REQ-003 The block SHALL have ports clk (in, 1): the single clock; rst (in, 1): reset, synchronous and active-high.
REQ-004 The block SHALL have ports start (in, 1): pulse that begins a load session; base_addr (in, ADDR_W): first memory address of the session.
REQ-005 The block SHALL have ports in_valid (in, 1); in_ready (out, 1); in_opcode (in, 4); in_is_imm (in, 1); in_util (in, 1); in_reg (in, 3); in_imm (in, 4): the instruction-field stream.
REQ-006 The block SHALL have port finish (in, 1): pulse that ends the session after all buffered instructions are written.
REQ-007 The block SHALL have ports mem_we (out, 1); mem_ready (in, 1); mem_addr (out, ADDR_W); mem_wdata (out, 8): the instruction-memory write port.
REQ-008 The block SHALL have ports busy (out, 1); done (out, 1); overflow (out, 1); count (out, ADDR_W+1): the number of instructions written this session.

Function
REQ-009 Encoding SHALL be insn[7:4]=in_opcode; insn[3:0]=in_imm when in_is_imm=1, else {in_util, in_reg}.
REQ-010 An input beat SHALL be accepted on a clk edge where in_valid=1 and in_ready=1, pushing the encoded byte into the FIFO.
REQ-011 in_ready SHALL be 1 only in state LOAD with the FIFO not full; full blocks pushes even when a pop happens in the same cycle.
REQ-012 A memory write SHALL occur on a clk edge where mem_we=1 and mem_ready=1; mem_we, mem_addr, and mem_wdata SHALL hold stable until that edge.
REQ-013 mem_we SHALL be 1 whenever the state is LOAD or DRAIN and the FIFO is not empty; mem_wdata SHALL equal the FIFO head.
REQ-014 An accepted beat SHALL appear on mem_wdata no earlier than the next cycle (minimum latency 1) and in acceptance order.
REQ-015 Each completed write SHALL pop the FIFO, increment mem_addr by 1, and increment count by 1.
REQ-016 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-017 The state machine SHALL use these states and transitions:
- IDLE -> LOAD on start; mem_addr<=base_addr; count<=0; overflow<=0; FIFO cleared.
- LOAD -> DRAIN on finish.
- DRAIN -> DONE when the FIFO is empty and no write is pending.
- DONE -> LOAD on start, with the same actions as IDLE -> LOAD.
- Any state except ERR -> ERR on overflow.
- ERR -> LOAD on start.
REQ-018 finish in LOAD with the FIFO empty SHALL reach DONE in two cycles (via DRAIN).
REQ-019 start while in LOAD or DRAIN SHALL be ignored.
REQ-020 finish outside LOAD SHALL be ignored.
REQ-021 start and finish asserted in the same cycle while in IDLE SHALL take only start.
REQ-022 A write completing at mem_addr = 2^ADDR_W-1 SHALL set overflow=1 and enter ERR; no further writes occur and mem_addr SHALL not wrap.
REQ-023 In ERR, in_ready=0 and mem_we=0 SHALL hold, and remaining FIFO content is discarded.
REQ-024 Outputs SHALL be driven as follows: busy=1 in LOAD or DRAIN; done=1 in DONE only; overflow SHALL stay 1 until the next start or rst.

Reset
REQ-025 rst SHALL, on a clk edge, put the block in IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, count=0, and an empty FIFO.
REQ-026 rst asserted mid-session SHALL abandon the session; the write in flight at that edge SHALL not complete.
REQ-027 rst SHALL take priority over start, finish, and all handshakes.

Structure
REQ-028 Opcode width (4), register field width (3), immediate width (4), instruction width (8), and the state encoding SHALL live in the shared CPU package used by the instruction decoder.
REQ-029 The FIFO SHALL be one sub-module, insn_fifo (parameterised by depth and width, with push/pop/full/empty).

Verification
REQ-030 start base_addr=0x10, beats {op=0x1, reg=3, util=0} and {op=0xC, imm=0x5, is_imm=1}, then finish, mem_ready=1 -> writes 0x13@0x10 and 0xC5@0x11; then count=2, done=1.
REQ-031 mem_ready=0 for 10 cycles with 6 beats offered -> in_ready drops after 4 accepts; mem_addr/mem_wdata are stable; after release all 6 bytes are written in order.
REQ-032 start base_addr=0xFE, 3 beats -> writes at 0xFE and 0xFF, then overflow=1, state ERR, third byte never written, count=2.
REQ-033 rst asserted after 2 of 4 writes -> all outputs at reset values next cycle; a new start at 0x00 writes from 0x00.
REQ-034 finish with no beats -> done=1 two cycles later, count=0, mem_we never asserted.
REQ-035 Constant push/pop at full throughput (mem_ready=1) -> one write per cycle, no in_ready bubbles.

Source files
------------

// File: rtl/insn_encoder_pkg.sv
// Shared CPU instruction-format package: field widths, encoder state encoding
// and the byte-packing helper used by the encoder and the instruction decoder.
package insn_encoder_pkg;

  localparam int OPCODE_W = 4;
  localparam int REG_W    = 3;
  localparam int IMM_W    = 4;
  localparam int INSN_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } enc_state_t;

  // Low nibble carries the immediate, or {util, reg} for register forms.
  function automatic logic [INSN_W-1:0] encode_insn(
    input logic [OPCODE_W-1:0] opcode,
    input logic                is_imm,
    input logic                util,
    input logic [REG_W-1:0]    rg,
    input logic [IMM_W-1:0]    imm
  );
    return is_imm ? {opcode, imm} : {opcode, util, rg};
  endfunction

endpackage

// File: rtl/insn_fifo.sv
// Small register-based FIFO with synchronous clear; the head reads as zero
// when empty so downstream data is clean after reset or a flush.
module insn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through dout while non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/insn_encoder.sv
// Packs instruction fields into bytes, buffers them, and streams them into
// instruction memory from a session base address, stopping at the top of memory.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic                in_is_imm,
  input  logic                in_util,
  input  logic [REG_W-1:0]    in_reg,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic                finish,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INSN_W-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     count
);

  // state    | meaning
  // ST_IDLE  | after reset, waiting for start
  // ST_LOAD  | accepting beats and writing buffered bytes
  // ST_DRAIN | finish seen, writing out what is still buffered
  // ST_DONE  | session complete, waiting for next start
  // ST_ERR   | write hit the last address, buffer discarded

  enc_state_t        state;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_clr;
  logic              push;
  logic              pop;
  logic              start_ok;
  logic              wrap_hit;
  logic [INSN_W-1:0] enc_byte;

  assign enc_byte  = encode_insn(in_opcode, in_is_imm, in_util, in_reg, in_imm);
  assign in_ready  = (state == ST_LOAD) && !fifo_full;
  assign mem_we    = ((state == ST_LOAD) || (state == ST_DRAIN)) && !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = mem_we && mem_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign wrap_hit  = pop && (mem_addr == '1);
  assign fifo_clr  = start_ok || wrap_hit;

  insn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSN_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (push),
    .pop   (pop),
    .din   (enc_byte),
    .dout  (mem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // The write at the last address still counts, but the address holds.
      if (pop && !wrap_hit) mem_addr <= mem_addr + 1'b1;
      if (pop)              count    <= count + 1'b1;

      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_LOAD;
            mem_addr <= base_addr;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (wrap_hit) begin
            state    <= ST_ERR;
            overflow <= 1'b1;
            busy     <= 1'b0;
          end else if (finish) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (wrap_hit) begin
            state    <= ST_ERR;
            overflow <= 1'b1;
            busy     <= 1'b0;
          end else if (fifo_empty) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed sessions, encoding table and
// randomized traffic scored against a queue-based reference of memory writes.
module tb_insn_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_opcode = '0;
  logic          in_is_imm = 1'b0;
  logic          in_util = 1'b0;
  logic [2:0]    in_reg = '0;
  logic [3:0]    in_imm = '0;
  logic          finish = 1'b0;
  logic          mem_we;
  logic          mem_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  insn_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_is_imm(in_is_imm), .in_util(in_util), .in_reg(in_reg), .in_imm(in_imm),
    .finish(finish), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .overflow(overflow), .count(count)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  byte unsigned exp_q[$];
  byte unsigned wr_log[$];
  int  exp_addr = 0;
  int  writes_seen = 0;
  int  accepts = 0;
  bit  we_seen = 0;
  bit  ovf_now = 0;
  bit  rand_ready = 0;

  typedef struct {
    logic [3:0] op;
    logic       is_imm;
    logic       util;
    logic [2:0] rg;
    logic [3:0] imm;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  int b_op[6], b_ii[6], b_ut[6], b_rg[6], b_im[6];

  function automatic int model_encode(int op, int is_imm, int util, int rg, int imm);
    return is_imm != 0 ? op * 16 + imm : op * 16 + util * 8 + rg;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Observe handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    ovf_now = 0;
    if (!rst) begin
      if (mem_we) we_seen = 1;
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: wrote 0x%0h at 0x%0h with nothing pending", mem_wdata, mem_addr);
        end else begin
          check("wr_data", mem_wdata, exp_q.pop_front());
        end
        check("wr_addr", mem_addr, exp_addr);
        wr_log.push_back(mem_wdata);
        writes_seen++;
        if (exp_addr == 2**AW - 1) begin
          ovf_now = 1;
          exp_q.delete();
        end else begin
          exp_addr++;
        end
      end
      if (in_valid && in_ready) begin
        accepts++;
        if (!ovf_now)
          exp_q.push_back(8'(model_encode(in_opcode, in_is_imm, in_util, in_reg, in_imm)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start(input int base);
    base_addr = AW'(base);
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.delete();
    wr_log.delete();
    exp_addr = base;
    writes_seen = 0;
    accepts = 0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic send_beat(input int op, input int ii, input int ut, input int rg, input int im);
    bit acc;
    int n;
    in_opcode = 4'(op); in_is_imm = 1'(ii); in_util = 1'(ut); in_reg = 3'(rg); in_imm = 4'(im);
    in_valid = 1'b1;
    n = 0;
    acc = 0;
    while (!acc && n < 200) begin
      acc = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic send_rand_beat();
    send_beat($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 15));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 500) begin
      step();
      n++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_count"}, count, 0);
  endtask

  initial begin
    tbl[0] = '{4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 8'h00};
    tbl[1] = '{4'hF, 1'b1, 1'b0, 3'd0, 4'hF, 8'hFF};
    tbl[2] = '{4'hA, 1'b0, 1'b1, 3'd7, 4'h0, 8'hAF};
    tbl[3] = '{4'h3, 1'b0, 1'b1, 3'd2, 4'h9, 8'h3A};
    tbl[4] = '{4'h5, 1'b1, 1'b1, 3'd7, 4'h0, 8'h50};
    tbl[5] = '{4'h7, 1'b0, 1'b0, 3'd5, 4'hF, 8'h75};
    tbl[6] = '{4'h9, 1'b1, 1'b0, 3'd0, 4'h6, 8'h96};
    tbl[7] = '{4'hC, 1'b0, 1'b1, 3'd0, 4'h0, 8'hC8};

    // reset values
    step(); step();
    rst = 1'b0;
    step();
    check_reset_vals("reset");

    // basic two-beat session
    mem_ready = 1'b1;
    do_start(8'h10);
    check("basic_busy", busy, 1);
    send_beat(1, 0, 0, 3, 0);
    send_beat(12, 1, 0, 0, 5);
    do_finish();
    wait_done();
    check("basic_count", count, 2);
    check("basic_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("basic_byte0", wr_log[0], 8'h13);
      check("basic_byte1", wr_log[1], 8'hC5);
    end
    check("basic_busy_after", busy, 0);

    // encoding table, also a DONE -> LOAD restart
    do_start(8'h40);
    for (int i = 0; i < 8; i++)
      send_beat(tbl[i].op, tbl[i].is_imm, tbl[i].util, tbl[i].rg, tbl[i].imm);
    do_finish();
    wait_done();
    check("tbl_nwrites", wr_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wr_log.size()) check($sformatf("tbl_enc%0d", i), wr_log[i], tbl[i].exp);

    // backpressure: 6 beats offered, memory stalled for 10 cycles
    for (int i = 0; i < 6; i++) begin
      b_op[i] = $urandom_range(0, 15); b_ii[i] = $urandom_range(0, 1);
      b_ut[i] = $urandom_range(0, 1);  b_rg[i] = $urandom_range(0, 7);
      b_im[i] = $urandom_range(0, 15);
    end
    mem_ready = 1'b0;
    do_start(8'h20);
    begin
      int bi = 0;
      for (int c = 0; c < 10; c++) begin
        bit acc;
        in_opcode = 4'(b_op[bi]); in_is_imm = 1'(b_ii[bi]); in_util = 1'(b_ut[bi]);
        in_reg = 3'(b_rg[bi]); in_imm = 4'(b_im[bi]);
        in_valid = 1'b1;
        if (c >= 1) begin
          check("stall_we", mem_we, 1);
          check("stall_addr", mem_addr, 8'h20);
          check("stall_data", mem_wdata, model_encode(b_op[0], b_ii[0], b_ut[0], b_rg[0], b_im[0]));
        end
        acc = in_ready;
        step();
        if (acc) bi++;
      end
      in_valid = 1'b0;
      check("stall_accepts", accepts, 4);
      check("stall_in_ready", in_ready, 0);
      mem_ready = 1'b1;
      for (int i = bi; i < 6; i++) send_beat(b_op[i], b_ii[i], b_ut[i], b_rg[i], b_im[i]);
    end
    do_finish();
    wait_done();
    check("stall_count", count, 6);
    check("stall_nwrites", writes_seen, 6);

    // overflow at the top of memory
    do_start(8'hFE);
    for (int i = 0; i < 3; i++) send_rand_beat();
    step(); step(); step();
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 2);
    check("ovf_nwrites", writes_seen, 2);
    check("ovf_addr_nowrap", mem_addr, 8'hFF);
    check("ovf_busy", busy, 0);
    check("ovf_done", done, 0);
    check("ovf_we", mem_we, 0);
    check("ovf_in_ready", in_ready, 0);
    do_finish();
    check("ovf_sticky", overflow, 1);
    check("ovf_finish_ignored", done, 0);
    do_start(8'h00);
    check("ovf_cleared", overflow, 0);
    check("ovf_restart_busy", busy, 1);
    do_finish();
    wait_done();

    // reset in the middle of a session
    mem_ready = 1'b0;
    do_start(8'h50);
    for (int i = 0; i < 4; i++) send_rand_beat();
    mem_ready = 1'b1;
    step(); step();
    check("rstmid_writes", writes_seen, 2);
    rst = 1'b1;
    step();
    check_reset_vals("rstmid");
    check("rstmid_no_third", writes_seen, 2);
    rst = 1'b0;
    exp_q.delete();
    step();
    do_start(8'h00);
    send_rand_beat();
    send_rand_beat();
    do_finish();
    wait_done();
    check("rstmid_count", count, 2);

    // finish with no beats
    do_start(8'h30);
    we_seen = 0;
    do_finish();
    check("empty_drain_done", done, 0);
    check("empty_drain_busy", busy, 1);
    step();
    check("empty_done", done, 1);
    check("empty_count", count, 0);
    check("empty_no_we", we_seen, 0);

    // full throughput
    mem_ready = 1'b1;
    do_start(8'h60);
    for (int i = 0; i < 8; i++) begin
      in_opcode = 4'($urandom_range(0, 15)); in_is_imm = 1'($urandom_range(0, 1));
      in_util = 1'($urandom_range(0, 1)); in_reg = 3'($urandom_range(0, 7));
      in_imm = 4'($urandom_range(0, 15));
      in_valid = 1'b1;
      check("tput_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    check("tput_writes", writes_seen, 7);
    do_finish();
    wait_done();
    check("tput_count", count, 8);

    // randomized sessions with random backpressure and an ignored mid-load start
    rand_ready = 1;
    for (int s = 0; s < 3; s++) begin
      do_start($urandom_range(0, 8'hC0));
      for (int i = 0; i < 20; i++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step();
        if (i == 10) begin
          start = 1'b1;
          base_addr = 8'h99;
          step();
          start = 1'b0;
        end
        send_rand_beat();
      end
      do_finish();
      wait_done();
      check($sformatf("rand%0d_count", s), count, 20);
      check($sformatf("rand%0d_writes", s), writes_seen, 20);
      check($sformatf("rand%0d_left", s), exp_q.size(), 0);
    end
    rand_ready = 0;
    mem_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
